// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execute stage with a one-bit-per-cycle shifter.
//
// A request is accepted only in IDLE (start=1). It then passes through EXEC, through SHIFT
// for non-zero shift amounts, and through a single WB cycle in which done is pulsed.
// write is pulsed in WB together with dr/wrData when the result goes to the register bank.
// err is pulsed with done for an illegal opcode or an out-of-range destination.
// Flags {C,V,Z,S} are registered and held between operations.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               request, sampled only in IDLE
//   opcode, a, b, dr_in operation, operands, destination index
//   busy                high in every state except IDLE
//   write, dr, wrData   register-bank write strobe, index and data
//   done, err           completion pulse and error pulse
//   flags               {C,V,Z,S}
module exec_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        dr_in,
    output logic              busy,
    output logic              write,
    output logic [4:0]        dr,
    output logic [DATA_W-1:0] wrData,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpNot = 4'd5;
    localparam logic [3:0] OpSll = 4'd6;
    localparam logic [3:0] OpSrl = 4'd7;
    localparam logic [3:0] OpSra = 4'd8;
    localparam logic [3:0] OpMov = 4'd9;
    localparam logic [3:0] OpCmp = 4'd10;

    typedef enum logic [1:0] {StIdle, StExec, StShift, StWb} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;      // operand A, doubles as the shift register
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        rd_q, rd_d;    // requested destination
    logic [4:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [4:0]        dr_q, dr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic [3:0]        flags_q, flags_d;

    // Single-cycle ALU
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;
    logic              is_shift, legal, writes, dr_ok;

    // One-bit shift step
    logic [DATA_W-1:0] sh_next;
    logic              sh_out;

    // Completion values fed into the WB registers
    logic              fin;
    logic [DATA_W-1:0] fin_res;
    logic              fin_c, fin_v;

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        is_shift = (op_q == OpSll) || (op_q == OpSrl) || (op_q == OpSra);
        legal    = (op_q <= OpCmp);
        writes   = legal && (op_q != OpCmp);
        dr_ok    = (32'(rd_q) < NUM_REGS);

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                          (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            OpSub, OpCmp: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = ~diff[DATA_W];  // no borrow means a >= b
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                          (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpXor: alu_res = a_q ^ b_q;
            OpNot: alu_res = ~a_q;
            OpMov: alu_res = b_q;
            OpSll, OpSrl, OpSra: alu_res = a_q;  // only reached for a zero shift
            default: alu_res = '0;
        endcase

        case (op_q)
            OpSrl: begin
                sh_next = {1'b0, a_q[DATA_W-1:1]};
                sh_out  = a_q[0];
            end
            OpSra: begin
                sh_next = {a_q[DATA_W-1], a_q[DATA_W-1:1]};
                sh_out  = a_q[0];
            end
            default: begin
                sh_next = {a_q[DATA_W-2:0], 1'b0};
                sh_out  = a_q[DATA_W-1];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        write_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        dr_d     = dr_q;
        wrdata_d = wrdata_q;
        flags_d  = flags_q;
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StExec;
                    op_d    = opcode;
                    a_d     = a;
                    b_d     = b;
                    rd_d    = dr_in;
                end
            end
            StExec: begin
                if (is_shift && (b_q[4:0] != 5'd0)) begin
                    state_d = StShift;
                    cnt_d   = b_q[4:0];
                end else begin
                    state_d = StWb;
                    fin     = 1'b1;
                    fin_res = alu_res;
                    fin_c   = alu_c;
                    fin_v   = alu_v;
                end
            end
            StShift: begin
                a_d   = sh_next;
                cnt_d = cnt_q - 5'd1;
                // Last step: the bit leaving now is the carry
                if (cnt_q == 5'd1) begin
                    state_d = StWb;
                    fin     = 1'b1;
                    fin_res = sh_next;
                    fin_c   = sh_out;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fin) begin
            done_d = 1'b1;
            if (!legal) begin
                err_d = 1'b1;
            end else begin
                flags_d = {fin_c, fin_v, (fin_res == '0), fin_res[DATA_W-1]};
                if (writes) begin
                    if (dr_ok) begin
                        write_d  = 1'b1;
                        dr_d     = rd_q;
                        wrdata_d = fin_res;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dr_q     <= '0;
            wrdata_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dr_q     <= dr_d;
            wrdata_q <= wrdata_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign write  = write_q;
    assign done   = done_q;
    assign err    = err_q;
    assign dr     = dr_q;
    assign wrData = wrdata_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected completions from a reference
// model; an independent monitor pops and compares whenever done is seen.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] a, b;
    logic [4:0]  dr_in;
    logic        busy, write, done, err;
    logic [4:0]  dr;
    logic [31:0] wrData;
    logic [3:0]  flags;

    exec_unit #(.DATA_W(32), .NUM_REGS(18)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .dr_in  (dr_in),
        .busy   (busy),
        .write  (write),
        .dr     (dr),
        .wrData (wrData),
        .done   (done),
        .err    (err),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        er;
        logic [4:0]  d;
        logic [31:0] data;
        logic [3:0]  fl;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    // Reference state: flags and last written dr/data are held across operations
    logic [3:0]  m_flags = '0;
    logic [4:0]  m_dr    = '0;
    logic [31:0] m_wr    = '0;

    task automatic push_expect(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input logic [4:0] d, input int issue_edge);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] res;
        logic        c, v;
        longint      sa, sb_l, sr;
        int          s;
        s    = int'(bv[4:0]);
        sa   = $signed(av);
        sb_l = $signed(bv);
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            4'd0: begin
                full = {1'b0, av} + {1'b0, bv};
                res  = full[31:0];
                c    = full[32];
                sr   = sa + sb_l;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1, 4'd10: begin
                res = av - bv;
                c   = (av >= bv);
                sr  = sa - sb_l;
                v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: res = av & bv;
            4'd3: res = av | bv;
            4'd4: res = av ^ bv;
            4'd5: res = ~av;
            4'd6: begin
                res = av << s;
                c   = (s == 0) ? 1'b0 : av[32-s];
            end
            4'd7: begin
                res = av >> s;
                c   = (s == 0) ? 1'b0 : av[s-1];
            end
            4'd8: begin
                res = 32'($signed(av) >>> s);
                c   = (s == 0) ? 1'b0 : av[s-1];
            end
            4'd9: res = bv;
            default: res = '0;
        endcase
        e.wr = 1'b0;
        e.er = 1'b0;
        if (op > 4'd10) begin
            e.er = 1'b1;
        end else begin
            m_flags = {c, v, (res == 32'd0), res[31]};
            if (op != 4'd10) begin
                if (d < 5'd18) begin
                    e.wr = 1'b1;
                    m_dr = d;
                    m_wr = res;
                end else begin
                    e.er = 1'b1;
                end
            end
        end
        e.d     = m_dr;
        e.data  = m_wr;
        e.fl    = m_flags;
        e.lat   = ((op >= 4'd6) && (op <= 4'd8) && (s > 0)) ? 1 + s : 1;
        e.issue = issue_edge;
        sb.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("write",   write,  mon_e.wr);
                    check("err",     err,    mon_e.er);
                    check("dr",      dr,     mon_e.d);
                    check("wrData",  wrData, mon_e.data);
                    check("flags",   flags,  mon_e.fl);
                    check("busy_wb", busy,   1'b1);
                    check("latency", edge_cnt - mon_e.issue, mon_e.lat);
                end
            end else if (write || err) begin
                check("strobe_without_done", {write, err}, 2'b00);
            end
        end
    end

    // Called at a negedge; waits for IDLE (optionally pulsing junk start), then issues.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] d, input bit noise, input bit track);
        int guard = 0;
        while (busy && guard < 200) begin
            start  = noise && ($urandom_range(0, 2) == 0);
            opcode = 4'($urandom);
            a      = $urandom;
            b      = $urandom;
            dr_in  = 5'($urandom);
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_wait", busy, 1'b0);
        start  = 1'b1;
        opcode = op;
        a      = av;
        b      = bv;
        dr_in  = d;
        if (track) push_expect(op, av, bv, d, edge_cnt + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        start = 1'b0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        int          done_seen;
        logic [3:0]  op;
        logic [31:0] av, bv;
        logic [4:0]  d;

        reset = 1'b1;
        start = 1'b0;
        opcode = '0;
        a = '0;
        b = '0;
        dr_in = '0;
        #3;
        check("rst_busy",   busy,   1'b0);
        check("rst_write",  write,  1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_err",    err,    1'b0);
        check("rst_dr",     dr,     5'd0);
        check("rst_wrData", wrData, 32'd0);
        check("rst_flags",  flags,  4'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ADD wrap: first start straight after reset release
        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b0, 1'b1);
        wait_idle(bc);
        check("add_busy_cycles", bc, 2);
        check("add_wrData", wrData, 32'd0);
        check("add_flags",  flags,  4'b1010);
        check("add_dr",     dr,     5'd3);

        issue(4'd1, 32'h8000_0000, 32'd1, 5'd5, 1'b0, 1'b1);
        wait_idle(bc);
        check("sub_wrData", wrData, 32'h7FFF_FFFF);
        check("sub_flags",  flags,  4'b1100);

        // SRA with junk start pulses while busy
        issue(4'd8, 32'h8000_0010, 32'd4, 5'd7, 1'b0, 1'b1);
        issue(4'd2, 32'h0F0F_0000, 32'hFFFF_0000, 5'd1, 1'b1, 1'b1);
        wait_idle(bc);
        issue(4'd8, 32'h8000_0010, 32'd4, 5'd7, 1'b0, 1'b1);
        wait_idle(bc);
        check("sra_busy_cycles", bc, 6);
        check("sra_wrData", wrData, 32'hF800_0001);
        check("sra_flags",  flags,  4'b0001);

        issue(4'd10, 32'h1234, 32'h1234, 5'd2, 1'b0, 1'b1);
        wait_idle(bc);
        check("cmp_flags", flags, 4'b1010);
        check("cmp_wrData_held", wrData, 32'hF800_0001);

        issue(4'd12, $urandom, $urandom, 5'd4, 1'b0, 1'b1);
        wait_idle(bc);
        check("illegal_flags_held", flags, 4'b1010);

        // Abort a 20-bit shift with an asynchronous reset between clock edges
        issue(4'd6, 32'hFFFF_FFFF, 32'd20, 5'd9, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy",   busy,   1'b0);
        check("abort_write",  write,  1'b0);
        check("abort_flags",  flags,  4'd0);
        check("abort_dr",     dr,     5'd0);
        check("abort_wrData", wrData, 32'd0);
        m_flags = '0;
        m_dr    = '0;
        m_wr    = '0;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        issue(4'd9, 32'd0, 32'hABCD, 5'd18, 1'b0, 1'b1);
        wait_idle(bc);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            av = $urandom;
            bv = $urandom;
            if ($urandom_range(0, 4) == 0) bv[4:0] = 5'd0;
            if ($urandom_range(0, 7) == 0) d = 5'($urandom_range(18, 31));
            else d = 5'($urandom_range(0, 17));
            if (op == 4'd10) d = 5'($urandom_range(0, 17));
            issue(op, av, bv, d, 1'b1, 1'b1);
        end
        wait_idle(bc);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter: DATA_W, 32, datapath width (fixed at 32; other values unsupported).
REQ-002 Parameter: NUM_REGS, 18, register-bank entries (R0-R15, SP, PC); legal destination range 0..NUM_REGS-1.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: opcode  input  4  operation select.
REQ-007 Port: a  input  32  operand A (regbank rData1).
REQ-008 Port: b  input  32  operand B (regbank rData2).
REQ-009 Port: dr_in  input  5  destination register index.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: write  output  1  regbank write strobe, one-cycle pulse.
REQ-012 Port: dr  output  5  regbank destination index, valid while write=1.
REQ-013 Port: wrData  output  32  regbank write data, valid while write=1.
REQ-014 Port: done  output  1  one-cycle completion pulse, including no-write cases.
REQ-015 Port: err  output  1  one-cycle pulse coincident with done on illegal opcode or dr_in>=NUM_REGS.
REQ-016 Port: flags  output  4  {C,V,Z,S}, registered, held between operations.

Function
REQ-017 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SLL a by b[4:0]; 7 SRL; 8 SRA; 9 MOV b; 10 CMP (a-b, flags only, no write); 11-15 illegal.
REQ-018 States: IDLE, EXEC, SHIFT, WB; reset state IDLE.
REQ-019 IDLE: start=1 at edge k latches opcode, a, b, dr_in and enters EXEC; start=0 stays IDLE.
REQ-020 EXEC: opcodes 0-5, 9, 10, illegal, or shift with b[4:0]=0 -> WB at edge k+1 with result/flags registered; shift with b[4:0]>0 -> SHIFT, counter loaded with b[4:0].
REQ-021 SHIFT: one bit position per cycle; counter decrements each edge; at count reaching 0 -> WB; shift by s costs s cycles in SHIFT.
REQ-022 WB: lasts exactly one cycle; done=1; write=1 only for legal opcode other than CMP and dr<NUM_REGS; next state IDLE.
REQ-023 Latency start-sample to write: 2 edges for single-cycle ops and zero shifts; 2+s edges for shift amount s>0.
REQ-024 write, done, err are registered outputs asserted only in WB; dr/wrData hold last value otherwise.
REQ-025 start while busy=1 is ignored, not queued; start in the WB cycle is also ignored.
REQ-026 Arithmetic modulo 2^32; ADD C = carry out of bit 31; SUB/CMP C = 1 when a>=b unsigned (no borrow); V = signed overflow.
REQ-027 Z = result==0; S = result[31]; ADD/SUB/CMP update C,V,Z,S.
REQ-028 Logic ops and MOV update Z,S and clear C,V.
REQ-029 Shifts: C = last bit shifted out (0 for zero shift), V=0, Z,S from result; SRA replicates a[31].
REQ-030 Illegal opcode: no write, flags unchanged, err=1 with done.
REQ-031 dr_in>=NUM_REGS with legal writing opcode: flags updated, no write, err=1 with done.

Reset
REQ-032 reset=1 forces IDLE immediately, asynchronously, regardless of clock.
REQ-033 Reset values: busy=0, write=0, done=0, err=0, dr=0, wrData=0, flags=0, shift counter=0.
REQ-034 Reset mid-operation aborts it; no write or done pulse is produced for the aborted request.
REQ-035 First start honoured at the first posedge after reset deasserts.

Verification
REQ-036 ADD a=0xFFFFFFFF, b=1, dr_in=3 -> two edges later write=1, dr=3, wrData=0, flags C=1,V=0,Z=1,S=0; busy high 2 cycles.
REQ-037 SUB a=0x80000000, b=1, dr_in=5 -> wrData=0x7FFFFFFF, C=1, V=1, Z=0, S=0.
REQ-038 SRA a=0x80000010, b=4, dr_in=7 -> 4 SHIFT cycles, write at edge 6, wrData=0xF8000001, C=0; start pulsed mid-shift ignored.
REQ-039 CMP a=b=0x1234 -> done=1, write=0, Z=1, C=1; opcode 12 -> done=1, err=1, write=0, flags unchanged.
REQ-040 MOV b=0xABCD, dr_in=18 -> err=1, write=0; reset asserted mid-SHIFT of a 20-bit shift -> busy=0 asynchronously, no write, flags=0.
